// File: rtl/conv_pkg.sv
// Shared types for the convolution sequencer: FSM state encoding and the read tag
// that travels alongside each weight read until its data comes back.
package conv_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_MAX_TAPS = 8;
    localparam int DEF_RD_LAT   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } conv_state_t;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
        logic bias;
    } rd_tag_t;

endpackage

// File: rtl/conv_rd_pipe.sv
// Delays each read tag by the SRAM read latency so MAC/bias controls line up with read data;
// NL_EN trails the last tap of an output by one further cycle.
module conv_rd_pipe
    import conv_pkg::*;
#(
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic    CLK,
    input  logic    RSTL,
    input  rd_tag_t i_tag,
    output logic    o_mac_en,
    output logic    o_mac_clr,
    output logic    o_bias_ld,
    output logic    o_nl_en
);

    rd_tag_t r_sr [RD_LAT];
    logic    r_nl;
    rd_tag_t w_out;

    assign w_out = r_sr[RD_LAT-1];

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            for (int i = 0; i < RD_LAT; i++) r_sr[i] <= '0;
            r_nl <= 1'b0;
        end else begin
            r_sr[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) r_sr[i] <= r_sr[i-1];
            r_nl <= w_out.vld & w_out.last;
        end
    end

    assign o_mac_en  = w_out.vld & ~w_out.bias;
    assign o_mac_clr = w_out.vld & w_out.first;
    assign o_bias_ld = w_out.vld & w_out.bias;
    assign o_nl_en   = r_nl;

endmodule

// File: rtl/conv_seq_p.sv
// Convolution sequencer: streams contiguous weight reads for COUNTER0 outputs of N taps each.
// Define CONV_BIAS_EN to prefix every output with one bias-word read.
module conv_seq_p
    import conv_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_TAPS = DEF_MAX_TAPS,
    parameter int RD_LAT   = DEF_RD_LAT,
    localparam int TAP_W   = $clog2(MAX_TAPS + 1)
) (
    input  logic              CLK,
    input  logic              RSTL,
    input  logic              CONV_CAL,
    input  logic              module_busy,
    input  logic [CNT_W-1:0]  COUNTER0,
    input  logic [TAP_W-1:0]  TAPS_I,
    input  logic [ADDR_W-1:0] RADDRW_I,
    input  logic              HOLD,
    output logic [ADDR_W-1:0] RADDRW,
    output logic              RCEBW,
    output logic              MAC_EN,
    output logic              MAC_CLR,
    output logic              NL_EN,
    output logic              BIAS_LD,
    output logic              CONV_BUSY,
    output logic              DONE
);

`ifdef CONV_BIAS_EN
    localparam int BIAS_N = 1;
`else
    localparam int BIAS_N = 0;
`endif
    localparam int RT_W = TAP_W + 1;
    localparam logic [TAP_W-1:0] MAX_T = TAP_W'(MAX_TAPS);

    conv_state_t       r_state;
    logic [RT_W-1:0]   r_reads;
    logic [RT_W-1:0]   r_tap;
    logic [CNT_W-1:0]  r_out;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rceb;
    logic [2:0]        r_dly;
    logic              r_done;

    logic [TAP_W-1:0]  w_taps;
    logic [RT_W-1:0]   w_reads;
    logic              w_first;
    logic              w_last;
    logic              w_final;
    logic              w_bias;
    rd_tag_t           w_tag;

    assign w_taps  = (TAPS_I == '0 || TAPS_I > MAX_T) ? MAX_T : TAPS_I;
    assign w_reads = {1'b0, w_taps} + RT_W'(BIAS_N);

    // Counters describe the read currently on RCEBW/RADDRW (remaining, including this one).
    assign w_first = (r_tap == (r_reads - RT_W'(BIAS_N)));
    assign w_last  = (r_tap == RT_W'(1));
    assign w_final = w_last && (r_out == CNT_W'(1));
`ifdef CONV_BIAS_EN
    assign w_bias  = (r_tap == r_reads);
`else
    assign w_bias  = 1'b0;
`endif

    assign w_tag = '{vld: ~r_rceb, first: w_first, last: w_last, bias: w_bias};

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            r_state <= IDLE;
            r_reads <= '0;
            r_tap   <= '0;
            r_out   <= '0;
            r_addr  <= '0;
            r_rceb  <= 1'b1;
            r_dly   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (CONV_CAL && !module_busy) begin
                        if (COUNTER0 == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ISSUE;
                            r_reads <= w_reads;
                            r_tap   <= w_reads;
                            r_out   <= COUNTER0;
                            r_addr  <= RADDRW_I;
                            r_rceb  <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    // Counters step when a read completes its issue cycle, even if HOLD then stalls.
                    if (!r_rceb) begin
                        if (w_final) begin
                            r_state <= DRAIN;
                            r_dly   <= 3'(RD_LAT);
                        end else if (w_last) begin
                            r_tap <= r_reads;
                            r_out <= r_out - CNT_W'(1);
                        end else begin
                            r_tap <= r_tap - RT_W'(1);
                        end
                    end
                    if ((!r_rceb && w_final) || HOLD) begin
                        r_rceb <= 1'b1;
                    end else begin
                        r_rceb <= 1'b0;
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (r_dly == 3'd1) r_state <= FIN;
                    else               r_dly   <= r_dly - 3'd1;
                end
                FIN: begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    conv_rd_pipe #(.RD_LAT(RD_LAT)) u_pipe (
        .CLK       (CLK),
        .RSTL      (RSTL),
        .i_tag     (w_tag),
        .o_mac_en  (MAC_EN),
        .o_mac_clr (MAC_CLR),
        .o_bias_ld (BIAS_LD),
        .o_nl_en   (NL_EN)
    );

    assign RADDRW    = r_addr;
    assign RCEBW     = r_rceb;
    assign CONV_BUSY = (r_state != IDLE);
    assign DONE      = r_done;

endmodule
